mem_stream_ctrl: RTL

MEM_STREAM_CTRL -- requirements
Module: mem_stream_ctrl

---
 rtl/mem_stream_pkg.sv | 17 +
 rtl/mem_addr_gen.sv | 42 ++++
 rtl/mem_stream_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory stream controller: command opcodes and FSM state encoding.
package mem_stream_pkg;

    localparam logic [1:0] OP_FILL  = 2'b00;
    localparam logic [1:0] OP_DUMP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DUMP  = 3'd2,
        CLEAR = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/mem_addr_gen.sv
// Loadable wrapping address pointer paired with a remaining-word down-counter.
module mem_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] load_ptr,
    input  logic [ADDR_WIDTH:0]   load_cnt,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic [ADDR_WIDTH:0]   remaining,
    output logic                  zero,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [ADDR_WIDTH:0]   rem_r;

    // Pointer/counter register; the pointer wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= {ADDR_WIDTH{1'b0}};
            rem_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (load) begin
            ptr_r <= load_ptr;
            rem_r <= load_cnt;
        end else if (step && (rem_r != {(ADDR_WIDTH+1){1'b0}})) begin
            ptr_r <= ptr_r + ADDR_WIDTH'(1);
            rem_r <= rem_r - (ADDR_WIDTH+1)'(1);
        end else begin
            ptr_r <= ptr_r;
            rem_r <= rem_r;
        end
    end

    assign ptr       = ptr_r;
    assign remaining = rem_r;
    assign zero      = (rem_r == {(ADDR_WIDTH+1){1'b0}});
    assign last      = (rem_r == (ADDR_WIDTH+1)'(1));

endmodule

// File: rtl/mem_stream_ctrl.sv
// Command-driven controller streaming words into (FILL), out of (DUMP) or zeroing (CLEAR) an external RAM.
module mem_stream_ctrl
    import mem_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic                  done
);

    state_t                state_r;
    state_t                state_s;
    logic                  load_s;
    logic                  step_s;
    logic [ADDR_WIDTH-1:0] load_ptr_s;
    logic [ADDR_WIDTH:0]   load_cnt_s;
    logic [ADDR_WIDTH-1:0] ptr_s;
    logic [ADDR_WIDTH:0]   remaining_s;
    logic                  zero_s;
    logic                  last_s;
    logic                  done_s;
    logic                  done_r;
    logic                  m_load_s;
    logic                  m_valid_s;
    logic                  m_valid_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic                  len_zero_s;

    mem_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .step      (step_s),
        .load_ptr  (load_ptr_s),
        .load_cnt  (load_cnt_s),
        .ptr       (ptr_s),
        .remaining (remaining_s),
        .zero      (zero_s),
        .last      (last_s)
    );

    assign len_zero_s = (cmd_len == {(ADDR_WIDTH+1){1'b0}});

    // Next-state, pointer control and datapath strobes.
    always_comb begin
        state_s    = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        load_ptr_s = cmd_base;
        load_cnt_s = cmd_len;
        done_s     = 1'b0;
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        mem_we     = 1'b0;
        mem_din    = {DATA_WIDTH{1'b0}};
        m_load_s   = 1'b0;
        m_valid_s  = m_valid_r;
        case (state_r)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_FILL, OP_DUMP: begin
                            if (len_zero_s) begin
                                done_s = 1'b1;
                            end else begin
                                load_s  = 1'b1;
                                state_s = (cmd_op == OP_FILL) ? FILL : DUMP;
                            end
                        end
                        OP_CLEAR: begin
                            load_s     = 1'b1;
                            load_ptr_s = {ADDR_WIDTH{1'b0}};
                            load_cnt_s = {1'b1, {ADDR_WIDTH{1'b0}}};
                            state_s    = CLEAR;
                        end
                        default: done_s = 1'b1;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                s_ready = 1'b1;
                mem_we  = s_valid;
                mem_din = s_valid ? s_data : {DATA_WIDTH{1'b0}};
                step_s  = s_valid && !zero_s;
                if (s_valid && last_s) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = FILL;
                end
            end
            CLEAR: begin
                mem_we = 1'b1;
                step_s = !zero_s;
                if (last_s) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = CLEAR;
                end
            end
            DUMP: begin
                // The output register refills whenever it is empty or being consumed.
                if (!m_valid_r || m_ready) begin
                    m_load_s  = 1'b1;
                    m_valid_s = 1'b1;
                    step_s    = !zero_s;
                    state_s   = last_s ? DRAIN : DUMP;
                end else begin
                    state_s = DUMP;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    m_valid_s = 1'b0;
                    state_s   = IDLE;
                    done_s    = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s   = IDLE;
                m_valid_s = 1'b0;
            end
        endcase
    end

    // State, completion pulse and read-data output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            done_r    <= 1'b0;
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= state_s;
            done_r    <= done_s;
            m_valid_r <= m_valid_s;
            if (m_load_s) begin
                m_data_r <= mem_dout;
            end else begin
                m_data_r <= m_data_r;
            end
        end
    end

    assign mem_addr = ptr_s;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign done     = done_r;
    assign busy     = (state_r != IDLE);

endmodule
